osc_gen: RTL and testbench

Parametrised multi-channel waveform oscillator. It produces synthesizable, clock-counted square waves with independently programmable high and low durations per channel. It is the successor to the delay-based asymmetric oscillator and is used as the pulse and strobe source for the stimulus and timing blocks. Configuration changes are double-buffered so that a running period is never torn.

---
 rtl/osc_pkg.sv | 25 ++
 rtl/osc_channel.sv | 147 ++++++++++++++
 rtl/osc_gen.sv | 44 ++++
 tb/tb_osc_gen.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osc_pkg.sv
// osc_pkg: state encoding and default parameters shared by osc_gen and osc_channel.
// Build option: OSC_PHASE_EN adds the WAIT state used for a per-channel phase offset.
package osc_pkg;

`ifdef OSC_PHASE_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        WAIT = 2'd3
    } osc_state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } osc_state_t;
`endif

    localparam int OSC_NUM_CH   = 4;
    localparam int OSC_CNT_W    = 8;
    localparam int OSC_DEF_HIGH = 10;
    localparam int OSC_DEF_LOW  = 30;

endpackage

// File: rtl/osc_channel.sv
// osc_channel: one oscillator channel - FSM, phase counter and pending/active
// duration registers. Build option: OSC_PHASE_EN adds the phase input and WAIT state.
//
// state | meaning
// IDLE  | stopped, output low; active durations track pending every cycle
// WAIT  | phase offset after enable, output low (OSC_PHASE_EN only)
// LOW   | counting the low duration, output low
// HIGH  | counting the high duration, output high; last cycle is the period boundary
module osc_channel
    import osc_pkg::*;
#(
    parameter int CNT_W    = OSC_CNT_W,
    parameter int DEF_HIGH = OSC_DEF_HIGH,
    parameter int DEF_LOW  = OSC_DEF_LOW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_load,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_low,
`ifdef OSC_PHASE_EN
    input  logic [CNT_W-1:0] phase,
`endif
    output logic             osc_out,
    output logic             period_tick
);

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HIGH);
    localparam logic [CNT_W-1:0] DEF_L = CNT_W'(DEF_LOW);

    osc_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_h_q, act_h_d;
    logic [CNT_W-1:0] act_l_q, act_l_d;
    logic [CNT_W-1:0] pend_h_q, pend_h_d;
    logic [CNT_W-1:0] pend_l_q, pend_l_d;
    logic             tick_q, tick_d;

    // A period starts in LOW unless it has no low phase but does have a high phase;
    // both zero parks the channel in LOW.
    function automatic osc_state_t entry_state(input logic [CNT_W-1:0] h,
                                               input logic [CNT_W-1:0] l);
        return (l == '0 && h != '0) ? HIGH : LOW;
    endfunction

    // Next-state, counter and duration-register update; pending_d doubles as the
    // boundary bypass value when cfg_load lands on the boundary cycle.
    always_comb begin
        pend_h_d = cfg_load ? cfg_high : pend_h_q;
        pend_l_d = cfg_load ? cfg_low  : pend_l_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        act_h_d  = act_h_q;
        act_l_d  = act_l_q;

        case (state_q)
            IDLE: begin
                act_h_d = pend_h_d;
                act_l_d = pend_l_d;
                cnt_d   = '0;
                if (en) begin
                    state_d = entry_state(pend_h_d, pend_l_d);
                end
`ifdef OSC_PHASE_EN
                if (en && phase != '0) begin
                    state_d = WAIT;
                end
`endif
            end
`ifdef OSC_PHASE_EN
            WAIT: begin
                if (phase == '0 || cnt_q >= phase - ONE) begin
                    cnt_d   = '0;
                    state_d = entry_state(act_h_q, act_l_q);
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
`endif
            LOW: begin
                if (act_l_q == '0 || cnt_q == act_l_q - ONE) begin
                    cnt_d = '0;
                    if (act_h_q != '0) begin
                        state_d = HIGH;
                    end else begin
                        // No high phase: the end of the low count is the only
                        // place new durations can take effect.
                        act_h_d = pend_h_d;
                        act_l_d = pend_l_d;
                        state_d = entry_state(pend_h_d, pend_l_d);
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            HIGH: begin
                if (cnt_q == act_h_q - ONE) begin
                    cnt_d   = '0;
                    act_h_d = pend_h_d;
                    act_l_d = pend_l_d;
                    state_d = entry_state(pend_h_d, pend_l_d);
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end

        // Registered tick: flag the cycle that will be the last HIGH cycle.
        tick_d = (state_d == HIGH) && (cnt_d == act_h_d - ONE);
    end

    // State, counter, duration and tick registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            act_h_q  <= DEF_H;
            act_l_q  <= DEF_L;
            pend_h_q <= DEF_H;
            pend_l_q <= DEF_L;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            act_h_q  <= act_h_d;
            act_l_q  <= act_l_d;
            pend_h_q <= pend_h_d;
            pend_l_q <= pend_l_d;
            tick_q   <= tick_d;
        end
    end

    assign osc_out     = (state_q == HIGH);
    assign period_tick = tick_q;

endmodule

// File: rtl/osc_gen.sv
// osc_gen: NUM_CH independent clock-counted square-wave oscillators.
// Build option: OSC_PHASE_EN adds the packed per-channel phase input.
module osc_gen
    import osc_pkg::*;
#(
    parameter int NUM_CH   = OSC_NUM_CH,
    parameter int CNT_W    = OSC_CNT_W,
    parameter int DEF_HIGH = OSC_DEF_HIGH,
    parameter int DEF_LOW  = OSC_DEF_LOW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       cfg_load,
    input  logic [NUM_CH*CNT_W-1:0] cfg_high,
    input  logic [NUM_CH*CNT_W-1:0] cfg_low,
`ifdef OSC_PHASE_EN
    input  logic [NUM_CH*CNT_W-1:0] phase,
`endif
    output logic [NUM_CH-1:0]       osc_out,
    output logic [NUM_CH-1:0]       period_tick
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        osc_channel #(
            .CNT_W    (CNT_W),
            .DEF_HIGH (DEF_HIGH),
            .DEF_LOW  (DEF_LOW)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .en          (en[i]),
            .cfg_load    (cfg_load[i]),
            .cfg_high    (cfg_high[i*CNT_W +: CNT_W]),
            .cfg_low     (cfg_low[i*CNT_W +: CNT_W]),
`ifdef OSC_PHASE_EN
            .phase       (phase[i*CNT_W +: CNT_W]),
`endif
            .osc_out     (osc_out[i]),
            .period_tick (period_tick[i])
        );
    end

endmodule

// File: tb/tb_osc_gen.sv
// tb_osc_gen: directed sequences, a table of single-channel configurations and a
// randomized run, all checked against a period-position model of each channel.
module tb_osc_gen;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int DEF_H  = 10;
    localparam int DEF_L  = 30;

    typedef struct {
        int h;
        int l;
        int rise;
        int nh;
        int nt;
    } vec_t;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH-1:0]       cfg_load;
    logic [NUM_CH*CNT_W-1:0] cfg_high;
    logic [NUM_CH*CNT_W-1:0] cfg_low;
`ifdef OSC_PHASE_EN
    logic [NUM_CH*CNT_W-1:0] phase_v;
`endif
    logic [NUM_CH-1:0]       osc_out;
    logic [NUM_CH-1:0]       period_tick;

    int n_pass  = 0;
    int n_total = 0;

    // Reference: per channel, running flag, position within the current period
    // (negative while in the phase offset), active and pending durations.
    int m_run[NUM_CH];
    int m_pos[NUM_CH];
    int m_ah[NUM_CH];
    int m_al[NUM_CH];
    int m_ph[NUM_CH];
    int m_pl[NUM_CH];

    always #5 clk = ~clk;

    osc_gen #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .DEF_HIGH (DEF_H),
        .DEF_LOW  (DEF_L)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .cfg_load    (cfg_load),
        .cfg_high    (cfg_high),
        .cfg_low     (cfg_low),
`ifdef OSC_PHASE_EN
        .phase       (phase_v),
`endif
        .osc_out     (osc_out),
        .period_tick (period_tick)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, $signed(act), $signed(exp), $time);
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_run[c] = 0;
            m_pos[c] = 0;
            m_ah[c]  = DEF_H;
            m_al[c]  = DEF_L;
            m_ph[c]  = DEF_H;
            m_pl[c]  = DEF_L;
        end
    endfunction

    function automatic void model_edge();
        for (int c = 0; c < NUM_CH; c++) begin
            int uh, ul;
            uh = cfg_load[c] ? int'(cfg_high[c*CNT_W +: CNT_W]) : m_ph[c];
            ul = cfg_load[c] ? int'(cfg_low[c*CNT_W +: CNT_W])  : m_pl[c];
            m_ph[c] = uh;
            m_pl[c] = ul;
            if (m_run[c] == 0) begin
                m_ah[c]  = uh;
                m_al[c]  = ul;
                m_pos[c] = 0;
                if (en[c]) begin
                    m_run[c] = 1;
`ifdef OSC_PHASE_EN
                    m_pos[c] = -int'(phase_v[c*CNT_W +: CNT_W]);
`endif
                end
            end else if (!en[c]) begin
                m_run[c] = 0;
                m_pos[c] = 0;
            end else begin
                m_pos[c]++;
                if (m_pos[c] >= m_ah[c] + m_al[c]) begin
                    m_pos[c] = 0;
                    m_ah[c]  = uh;
                    m_al[c]  = ul;
                end
            end
        end
    endfunction

    task automatic step();
        logic [NUM_CH-1:0] eo, et;
        @(posedge clk);
        model_edge();
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            eo[c] = (m_run[c] != 0) && (m_ah[c] > 0) && (m_pos[c] >= m_al[c]);
            et[c] = (m_run[c] != 0) && (m_ah[c] > 0) && (m_pos[c] == m_ah[c] + m_al[c] - 1);
        end
        check("model_osc_out", 32'(osc_out), 32'(eo));
        check("model_period_tick", 32'(period_tick), 32'(et));
    endtask

    task automatic set_cfg(input int c, input int h, input int l);
        cfg_high[c*CNT_W +: CNT_W] = CNT_W'(h);
        cfg_low[c*CNT_W +: CNT_W]  = CNT_W'(l);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[8];
        int   rise, fall, nh, nt, found, prev, nrise;
        int   tk[3];
        int   rs[2];
        logic o34, o35, om0, om2;

        tbl[0] = '{10,  30, 30, 10,  1};
        tbl[1] = '{3,   5,  5,  18,  6};
        tbl[2] = '{4,   0,  0,  48, 12};
        tbl[3] = '{0,   7,  -1, 0,   0};
        tbl[4] = '{0,   0,  -1, 0,   0};
        tbl[5] = '{1,   1,  1,  24, 24};
        tbl[6] = '{255, 1,  1,  47,  0};
        tbl[7] = '{2,   2,  2,  24, 12};

        en       = '0;
        cfg_load = '0;
        cfg_high = '0;
        cfg_low  = '0;
`ifdef OSC_PHASE_EN
        phase_v  = '0;
`endif
        rst_n    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_osc_out", 32'(osc_out), 0);
        check("reset_period_tick", 32'(period_tick), 0);
        rst_n = 1'b1;

        // Defaults on channel 0: 30 low, 10 high, tick on cycle 39 and every 40.
        rise = -1; fall = -1; tk[0] = -1; tk[1] = -1;
        en[0] = 1'b1;
        for (int n = 0; n < 80; n++) begin
            step();
            if (osc_out[0] && rise < 0) rise = n;
            if (!osc_out[0] && rise >= 0 && fall < 0) fall = n;
            if (period_tick[0]) begin
                if (tk[0] < 0) tk[0] = n;
                else if (tk[1] < 0) tk[1] = n;
            end
        end
        check("default_rise", rise, 30);
        check("default_fall", fall, 40);
        check("default_tick1", tk[0], 39);
        check("default_tick2", tk[1], 79);

        // Mid-period update on channel 1: current period finishes, then 5 low / 3 high.
        tk = '{-1, -1, -1}; rs = '{-1, -1}; nt = 0; nrise = 0; prev = 0;
        en[1] = 1'b1;
        for (int n = 0; n < 60; n++) begin
            step();
            if (n == 10) begin
                set_cfg(1, 3, 5);
                cfg_load[1] = 1'b1;
            end
            if (n == 11) cfg_load[1] = 1'b0;
            if (period_tick[1] && nt < 3) begin
                tk[nt] = n;
                nt++;
            end
            if (osc_out[1] && prev == 0 && nrise < 2) begin
                rs[nrise] = n;
                nrise++;
            end
            prev = int'(osc_out[1]);
        end
        check("midupd_tick1", tk[0], 39);
        check("midupd_tick2", tk[1], 47);
        check("midupd_tick3", tk[2], 55);
        check("midupd_rise1", rs[0], 30);
        check("midupd_rise2", rs[1], 45);

        // Boundary bypass on channel 0: load presented during the tick cycle.
        found = 0;
        for (int n = 0; n < 100 && found == 0; n++) begin
            step();
            if (period_tick[0]) found = 1;
        end
        check("bypass_found_tick", found, 1);
        set_cfg(0, 2, 2);
        cfg_load[0] = 1'b1;
        step();
        cfg_load[0] = 1'b0;
        om0 = osc_out[0];
        om2 = 1'b0;
        tk[0] = -1; tk[1] = -1;
        for (int m = 1; m < 9; m++) begin
            step();
            if (m == 2) om2 = osc_out[0];
            if (period_tick[0]) begin
                if (tk[0] < 0) tk[0] = m;
                else if (tk[1] < 0) tk[1] = m;
            end
        end
        check("bypass_out_m0", om0, 0);
        check("bypass_out_m2", om2, 1);
        check("bypass_tick1", tk[0], 3);
        check("bypass_tick2", tk[1], 7);

        // Enable dropped on the 5th high cycle of channel 3, then full restart.
        o34 = 1'b0; o35 = 1'b1; nt = 0;
        en[3] = 1'b1;
        for (int n = 0; n < 46; n++) begin
            if (n == 35) en[3] = 1'b0;
            step();
            if (n == 34) o34 = osc_out[3];
            if (n == 35) o35 = osc_out[3];
            if (n >= 30 && period_tick[3]) nt++;
        end
        check("endrop_out_before", o34, 1);
        check("endrop_out_after", o35, 0);
        check("endrop_no_tick", nt, 0);
        en[3] = 1'b1;
        rise = -1;
        for (int n = 0; n < 40; n++) begin
            step();
            if (osc_out[3] && rise < 0) rise = n;
        end
        check("endrop_restart_rise", rise, 30);
        en[3] = 1'b0;

        // Asynchronous reset while channel 1 is high; defaults must come back.
        found = 0;
        for (int n = 0; n < 20 && found == 0; n++) begin
            step();
            if (osc_out[1]) found = 1;
        end
        check("rst_found_high", found, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_osc_out", 32'(osc_out), 0);
        check("rst_async_tick", 32'(period_tick), 0);
        model_reset();
        en       = '0;
        cfg_load = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        en[0] = 1'b1;
        en[1] = 1'b1;
        rise = -1; fall = -1; tk[0] = -1;
        for (int n = 0; n < 40; n++) begin
            step();
            if (osc_out[1] && rise < 0) rise = n;
            if (osc_out[0] && fall < 0) fall = n;
            if (period_tick[1] && tk[0] < 0) tk[0] = n;
        end
        check("rst_defaults_rise_ch1", rise, 30);
        check("rst_defaults_rise_ch0", fall, 30);
        check("rst_defaults_tick_ch1", tk[0], 39);
        en = '0;
        step();
        step();

`ifdef OSC_PHASE_EN
        // Phase offset of 6 ahead of the default 30-cycle low.
        phase_v[CNT_W-1:0] = CNT_W'(6);
        step();
        en[0] = 1'b1;
        rise = -1;
        for (int n = 0; n < 50; n++) begin
            step();
            if (osc_out[0] && rise < 0) rise = n;
        end
        check("phase6_rise", rise, 36);
        en[0] = 1'b0;
        step();
        phase_v = '0;
        step();
`endif

        // Configuration table on channel 2, 48 cycles from enable.
        for (int v = 0; v < 8; v++) begin
            en[2] = 1'b0;
            step();
            set_cfg(2, tbl[v].h, tbl[v].l);
            cfg_load[2] = 1'b1;
            step();
            cfg_load[2] = 1'b0;
            en[2] = 1'b1;
            rise = -1; nh = 0; nt = 0;
            for (int n = 0; n < 48; n++) begin
                step();
                if (osc_out[2]) begin
                    nh++;
                    if (rise < 0) rise = n;
                end
                if (period_tick[2]) nt++;
            end
            check($sformatf("vec%0d_rise", v), rise, tbl[v].rise);
            check($sformatf("vec%0d_high_cycles", v), nh, tbl[v].nh);
            check($sformatf("vec%0d_ticks", v), nt, tbl[v].nt);
        end
        en[2] = 1'b0;
        step();

        // Randomized enables and loads on all channels against the model.
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 24) == 0) en[c] = ~en[c];
                cfg_load[c] = ($urandom_range(0, 7) == 0);
                if (cfg_load[c]) set_cfg(c, int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
